// File: rtl/csi_sequence_parser_pkg.sv
// DataType: shared types and constants for the CSI escape-sequence parser.
//   cmd_t          - decoded command type reported on commandType
//   state_t        - parser state encoding
//   ESC, CSI_INTRO - sequence introducer bytes
//   MAX_PARAMS     - number of numeric parameters that are kept
//   default_param  - applies the per-command defaulting rule to one parameter
package DataType;

  typedef enum logic [3:0] {
    CUP = 4'd0,
    CUU = 4'd1,
    CUD = 4'd2,
    CUF = 4'd3,
    CUB = 4'd4,
    ED  = 4'd5,
    EL  = 4'd6
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ESC  = 2'd1,
    ST_CSI  = 2'd2
  } state_t;

  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] CSI_INTRO = 8'h5B;
  localparam logic [7:0] CAN       = 8'h18;
  localparam logic [7:0] SUB       = 8'h1A;
  localparam logic [7:0] SEMI      = 8'h3B;
  localparam int         MAX_PARAMS = 2;

  // Cursor moves treat a missing or zero count as 1; erase commands treat a
  // missing selector as 0 but keep an explicit 0.
  function automatic logic [7:0] default_param(cmd_t cmd, logic present,
                                               logic [7:0] value);
    if (cmd == ED || cmd == EL) begin
      return present ? value : 8'd0;
    end
    return (!present || value == 8'd0) ? 8'd1 : value;
  endfunction

endpackage

// File: rtl/csi_sequence_parser_param_accum.sv
// csi_param_accum: decimal accumulator for one CSI numeric parameter.
//   clk, rst     - clock, async active-low reset
//   clear        - zero the value and drop the present flag
//   digit_strobe - fold digit (0..9) into the value: value*10 + digit
//   digit        - decimal digit
//   value        - accumulated value, saturating at 255
//   present      - at least one digit seen since the last clear
module csi_param_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       digit_strobe,
  input  logic [3:0] digit,
  output logic [7:0] value,
  output logic       present
);

  logic [7:0]  value_q, value_d;
  logic        present_q, present_d;
  logic [11:0] next_val;

  always_comb begin
    value_d   = value_q;
    present_d = present_q;
    // 255*10 + 9 = 2559 fits in 12 bits, so the saturation check is exact.
    next_val  = 12'(value_q) * 12'd10 + 12'(digit);
    if (clear) begin
      value_d   = 8'd0;
      present_d = 1'b0;
    end else if (digit_strobe) begin
      value_d   = (next_val > 12'd255) ? 8'hFF : next_val[7:0];
      present_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q   <= 8'd0;
      present_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      present_q <= present_d;
    end
  end

  assign value   = value_q;
  assign present = present_q;

endmodule

// File: rtl/csi_sequence_parser.sv
// csi_sequence_parser: splits a byte stream into plain characters and
// decoded CSI cursor/erase commands.
//   clk, rst              - clock, async active-low reset
//   data_valid, data_in   - received byte strobe and value
//   commandReady          - one-cycle pulse, command valid on commandType/Pn1/Pn2
//   commandType, Pn1, Pn2 - decoded command and defaulted parameters
//   char_valid, char_out  - one-cycle pulse with a forwarded plain byte
//
// state   | meaning
// ST_IDLE | plain text; bytes forwarded, ESC starts a sequence
// ST_ESC  | ESC seen, waiting for '['
// ST_CSI  | inside CSI, collecting parameters until a final byte
module csi_sequence_parser
  import DataType::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       commandReady,
  output cmd_t       commandType,
  output logic [7:0] Pn1,
  output logic [7:0] Pn2,
  output logic       char_valid,
  output logic [7:0] char_out
);

  localparam logic [1:0] IDX_MAX = 2'(MAX_PARAMS);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       ignore_q, ignore_d;
  logic       command_ready_q, command_ready_d;
  cmd_t       command_type_q, command_type_d;
  logic [7:0] pn1_q, pn1_d;
  logic [7:0] pn2_q, pn2_d;
  logic       char_valid_q, char_valid_d;
  logic [7:0] char_out_q, char_out_d;

  logic       acc_clear;
  logic       digit_hit;
  logic       final_ok;
  cmd_t       final_cmd;
  logic [7:0] p0_val, p1_val;
  logic       p0_present, p1_present;

  csi_param_accum u_param0 (
    .clk          (clk),
    .rst          (rst),
    .clear        (acc_clear),
    .digit_strobe (digit_hit && idx_q == 2'd0),
    .digit        (data_in[3:0]),
    .value        (p0_val),
    .present      (p0_present)
  );

  csi_param_accum u_param1 (
    .clk          (clk),
    .rst          (rst),
    .clear        (acc_clear),
    .digit_strobe (digit_hit && idx_q == 2'd1),
    .digit        (data_in[3:0]),
    .value        (p1_val),
    .present      (p1_present)
  );

  always_comb begin
    final_ok  = 1'b1;
    final_cmd = CUP;
    case (data_in)
      8'h48, 8'h66: final_cmd = CUP;
      8'h41:        final_cmd = CUU;
      8'h42:        final_cmd = CUD;
      8'h43:        final_cmd = CUF;
      8'h44:        final_cmd = CUB;
      8'h4A:        final_cmd = ED;
      8'h4B:        final_cmd = EL;
      default:      final_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ignore_d        = ignore_q;
    command_ready_d = 1'b0;
    command_type_d  = command_type_q;
    pn1_d           = pn1_q;
    pn2_d           = pn2_q;
    char_valid_d    = 1'b0;
    char_out_d      = char_out_q;
    acc_clear       = 1'b0;
    digit_hit       = 1'b0;

    if (data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (data_in == ESC) begin
            state_d = ST_ESC;
          end else begin
            char_valid_d = 1'b1;
            char_out_d   = data_in;
          end
        end
        ST_ESC: begin
          if (data_in == CSI_INTRO) begin
            state_d   = ST_CSI;
            idx_d     = 2'd0;
            ignore_d  = 1'b0;
            acc_clear = 1'b1;
          end else if (data_in != ESC) begin
            state_d = ST_IDLE;
          end
        end
        ST_CSI: begin
          if (data_in == CAN || data_in == SUB) begin
            state_d = ST_IDLE;
          end else if (data_in == ESC) begin
            state_d = ST_ESC;
          end else if (data_in < 8'h20) begin
            state_d = ST_CSI;
          end else if (data_in[7]) begin
            state_d = ST_IDLE;
          end else if (data_in >= 8'h30 && data_in <= 8'h39) begin
            digit_hit = 1'b1;
          end else if (data_in == SEMI) begin
            if (idx_q < IDX_MAX) idx_d = idx_q + 2'd1;
          end else if (data_in >= 8'h40 && data_in <= 8'h7E) begin
            state_d = ST_IDLE;
            if (!ignore_q && final_ok) begin
              command_ready_d = 1'b1;
              command_type_d  = final_cmd;
              pn1_d           = default_param(final_cmd, p0_present, p0_val);
              pn2_d           = (final_cmd == CUP) ?
                                default_param(CUP, p1_present, p1_val) : 8'd0;
            end
          end else if (data_in != 8'h7F) begin
            // Intermediates, private markers and ':' make the sequence one
            // we do not act on; it still runs to its final byte.
            ignore_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= 2'd0;
      ignore_q        <= 1'b0;
      command_ready_q <= 1'b0;
      command_type_q  <= CUP;
      pn1_q           <= 8'd0;
      pn2_q           <= 8'd0;
      char_valid_q    <= 1'b0;
      char_out_q      <= 8'd0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ignore_q        <= ignore_d;
      command_ready_q <= command_ready_d;
      command_type_q  <= command_type_d;
      pn1_q           <= pn1_d;
      pn2_q           <= pn2_d;
      char_valid_q    <= char_valid_d;
      char_out_q      <= char_out_d;
    end
  end

  assign commandReady = command_ready_q;
  assign commandType  = command_type_q;
  assign Pn1          = pn1_q;
  assign Pn2          = pn2_q;
  assign char_valid   = char_valid_q;
  assign char_out     = char_out_q;

endmodule

// File: tb/tb_csi_sequence_parser.sv
// Testbench for csi_sequence_parser: directed byte sequences with expected
// commands/characters queued as each triggering byte is driven; a negedge
// monitor pops and compares every output pulse.
module tb_csi_sequence_parser;
  import DataType::*;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic [7:0] data_in;
  logic       commandReady;
  cmd_t       commandType;
  logic [7:0] Pn1;
  logic [7:0] Pn2;
  logic       char_valid;
  logic [7:0] char_out;

  csi_sequence_parser dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid   (data_valid),
    .data_in      (data_in),
    .commandReady (commandReady),
    .commandType  (commandType),
    .Pn1          (Pn1),
    .Pn2          (Pn2),
    .char_valid   (char_valid),
    .char_out     (char_out)
  );

  typedef struct {
    bit         is_cmd;
    cmd_t       t;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] ch;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output becomes visible at the first negedge after the sampling edge.
  task automatic exp_cmd(input cmd_t t, input logic [7:0] p1,
                         input logic [7:0] p2);
    exp_t e;
    e.is_cmd = 1'b1; e.t = t; e.p1 = p1; e.p2 = p2; e.ch = 8'h00;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic exp_char(input logic [7:0] c);
    exp_t e;
    e.is_cmd = 1'b0; e.t = CUP; e.p1 = 8'h00; e.p2 = 8'h00; e.ch = c;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    data_valid = 1'b1;
    data_in    = b;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    data_valid = 1'b0;
    data_in    = 8'h41;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && (commandReady || char_valid)) begin
      chk("exclusive_pulses", 32'(commandReady & char_valid), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {7'd0, commandReady, 8'd0, char_out, 8'd0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(commandReady), 32'(e.is_cmd));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_cmd) begin
          chk("commandType", 32'(commandType), 32'(e.t));
          chk("Pn1", 32'(Pn1), 32'(e.p1));
          chk("Pn2", 32'(Pn2), 32'(e.p2));
        end else begin
          chk("char_out", 32'(char_out), 32'(e.ch));
        end
      end
    end
  end

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    #12;
    chk("rst_commandReady", 32'(commandReady), 32'd0);
    chk("rst_char_valid", 32'(char_valid), 32'd0);
    chk("rst_commandType", 32'(commandType), 32'(CUP));
    chk("rst_Pn1", 32'(Pn1), 32'd0);
    chk("rst_Pn2", 32'(Pn2), 32'd0);
    chk("rst_char_out", 32'(char_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    gap(2);

    // CAN aborts a partial CSI; plain text around it is forwarded.
    exp_char(8'h41); send(8'h41);
    send(8'h1B); send(8'h5B); send(8'h33); send(8'h18);
    exp_char(8'h42); send(8'h42);
    // Private-marker sequence is swallowed without output.
    send(8'h1B); send(8'h5B); send(8'h3F); send(8'h32); send(8'h35); send(8'h68);
    gap(3);

    // Two parameters, multi-digit.
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h32); send(8'h3B);
    send(8'h34); send(8'h30);
    exp_cmd(CUP, 8'd12, 8'd40); send(8'h48);

    // Defaults: CUP -> 1;1, ED -> 0;0.
    send(8'h1B); send(8'h5B);
    exp_cmd(CUP, 8'd1, 8'd1); send(8'h48);
    send(8'h1B); send(8'h5B);
    exp_cmd(ED, 8'd0, 8'd0); send(8'h4A);

    // Saturation and zero-to-one defaulting.
    send(8'h1B); send(8'h5B); send(8'h39); send(8'h39); send(8'h39);
    exp_cmd(CUU, 8'd255, 8'd0); send(8'h41);
    send(8'h1B); send(8'h5B); send(8'h30);
    exp_cmd(CUF, 8'd1, 8'd0); send(8'h43);

    // Explicit ED selector, 'f' as CUP with only the second parameter.
    send(8'h1B); send(8'h5B); send(8'h32);
    exp_cmd(ED, 8'd2, 8'd0); send(8'h4A);
    send(8'h1B); send(8'h5B); send(8'h3B); send(8'h37);
    exp_cmd(CUP, 8'd1, 8'd7); send(8'h66);

    // Third parameter discarded; non-CUP Pn2 forced to 0; EL explicit 0 kept.
    send(8'h1B); send(8'h5B); send(8'h35); send(8'h3B); send(8'h36);
    send(8'h3B); send(8'h37);
    exp_cmd(CUB, 8'd5, 8'd0); send(8'h44);
    send(8'h1B); send(8'h5B); send(8'h30);
    exp_cmd(EL, 8'd0, 8'd0); send(8'h4B);

    // Embedded C0 ignored, idle cycles between bytes change nothing.
    send(8'h1B); gap(2); send(8'h5B); send(8'h36); send(8'h0A); gap(1);
    exp_cmd(CUD, 8'd6, 8'd0); send(8'h42);

    // High byte aborts; ESC followed by non-'[' discards the byte.
    send(8'h1B); send(8'h5B); send(8'h35); send(8'hC1);
    exp_char(8'h42); send(8'h42);
    send(8'h1B); send(8'h41);
    exp_char(8'h5A); send(8'h5A);

    // ESC inside CSI restarts the sequence.
    send(8'h1B); send(8'h5B); send(8'h35); send(8'h1B); send(8'h5B); send(8'h32);
    exp_cmd(EL, 8'd2, 8'd0); send(8'h4B);
    gap(2);

    // Reset mid-sequence: 0x44 afterwards must be plain text.
    send(8'h1B); send(8'h5B); send(8'h35);
    rst = 1'b0;
    #2;
    chk("midrst_Pn1", 32'(Pn1), 32'd0);
    chk("midrst_char_out", 32'(char_out), 32'd0);
    chk("midrst_commandType", 32'(commandType), 32'(CUP));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_char(8'h44); send(8'h44);
    gap(5);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
